// File: rtl/bus_register_bank_if.sv
// Bus-side signals of the destination register bank: write requests in,
// flattened register contents and write status out.
interface bus_register_bank_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]    bus_contents;
  logic [4:0]          dest_sel;
  logic                wr_en;
  logic                ba_zero;
  logic [18*WIDTH-1:0] regs_flat;
  logic                wr_pending;
  logic                wr_err;
  logic [15:0]         wr_count;

  modport master (
    output bus_contents, dest_sel, wr_en, ba_zero,
    input  regs_flat, wr_pending, wr_err, wr_count
  );

  modport slave (
    input  bus_contents, dest_sel, wr_en, ba_zero,
    output regs_flat, wr_pending, wr_err, wr_count
  );
endinterface

// File: rtl/bus_register_bank.sv
// R0-R15, HI, LO loaded from the registered source bus; each write request is
// delayed ALIGN edges so it captures the bus word selected alongside it.
module bus_register_bank #(
  parameter int WIDTH = 32,
  parameter int ALIGN = 1
) (
  input  logic               clk,
  input  logic               clr,
  bus_register_bank_if.slave bus
);
  localparam int NREGS = 18;

  logic [ALIGN-1:0]      vld_q;
  logic [ALIGN-1:0][4:0] dst_q;
  logic                  wr_err_q;
  logic [15:0]           wr_count_q;
  logic [15:0]           wr_count_d;
  logic                  req_ok;
  logic                  commit;
  logic [4:0]            commit_dst;

  assign req_ok     = bus.wr_en && (bus.dest_sel <= 5'd17);
  assign commit     = vld_q[ALIGN-1];
  assign commit_dst = dst_q[ALIGN-1];
  assign wr_count_d = commit ? wr_count_q + 16'd1 : wr_count_q;

  // Stage 0 takes the new request; the tail stage is the one that commits.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      vld_q <= '0;
      dst_q <= '0;
    end else begin
      vld_q[0] <= req_ok;
      dst_q[0] <= bus.dest_sel;
      for (int i = 1; i < ALIGN; i++) begin
        vld_q[i] <= vld_q[i-1];
        dst_q[i] <= dst_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_err_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      if (bus.wr_en && (bus.dest_sel > 5'd17)) begin
        wr_err_q <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic [WIDTH-1:0] reg_q;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        reg_q <= '0;
      end else if (commit && (commit_dst == 5'(gi))) begin
        reg_q <= bus.bus_contents;
      end
    end

    // Only the exported copy of R0 is masked; the stored value is kept.
    if (gi == 0) begin : g_r0
      assign bus.regs_flat[0 +: WIDTH] = bus.ba_zero ? '0 : reg_q;
    end else begin : g_rn
      assign bus.regs_flat[gi*WIDTH +: WIDTH] = reg_q;
    end
  end

  assign bus.wr_pending = |vld_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.wr_count   = wr_count_q;
endmodule

// File: doc/bus_register_bank.md
# bus_register_bank

Destination side of the CPU's shared 32-bit datapath bus: holds R0–R15, HI and LO and loads them from `bus_contents`. The source multiplexer registers its output, so a value driven onto the bus appears one clock after its select. This block therefore delays each destination write by a configurable number of cycles so it lands on the matching bus word. All register contents are exported flat, so they can feed the source multiplexer's data inputs directly.

## Interface
Parameters:
- `WIDTH`, 32, data width of the bus and of each register.
- `ALIGN`, 1, cycles between a write request and capture of `bus_contents`. Legal values are 1 or 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `bus_contents`  in  WIDTH  bus value from the source multiplexer.
- `dest_sel`  in  5  destination code: 0–15 = R0–R15, 16 = HI, 17 = LO, 18–31 illegal.
- `wr_en`  in  1  write request for `dest_sel`, sampled each rising edge.
- `ba_zero`  in  1  when high, the exported R0 field reads as 0; stored R0 is unchanged.
- `regs_flat`  out  18*WIDTH  register contents. Field k occupies bits [k*WIDTH +: WIDTH], k = destination code.
- `wr_pending`  out  1  high while at least one accepted write is in the alignment pipeline.
- `wr_err`  out  1  sticky flag set by an illegal destination.
- `wr_count`  out  16  count of completed writes, wrapping.

## Operation
- Request stage: on each rising edge, sample {`wr_en`, `dest_sel`}.
  - `wr_en`=1 with `dest_sel` ≤ 17: push {valid=1, dest} into an ALIGN-deep shift pipeline.
  - `wr_en`=1 with `dest_sel` ≥ 18: push valid=0 and set `wr_err`. `wr_err` stays set until `clr`.
  - `wr_en`=0: push valid=0.
- Commit stage: when the pipeline tail is valid, the register named by its dest loads `bus_contents` on that edge, and `wr_count` increments, wrapping at 0xFFFF to 0.
- Each dest is a distinct entry, so only one register is written per edge.
- One request may be accepted per cycle. Back-to-back requests, including to the same register, commit in order on consecutive edges.
- `wr_pending` is the OR of the valid bits of all pipeline stages.
- `ba_zero` is combinational on the R0 field of `regs_flat` only. A write to R0 while `ba_zero`=1 still updates stored R0.
- Reset (`clr`=1, any time):
  - All registers, pipeline valid bits, `wr_err` and `wr_count` clear to 0 immediately.
  - In-flight writes are discarded and never commit.
  - Requests are ignored while `clr` is high.

## Timing
- Reset values: `regs_flat`=0, `wr_pending`=0, `wr_err`=0, `wr_count`=0.
- ALIGN=1 latency:
  - Request sampled at edge N; register loads `bus_contents` at edge N+1.
  - New value visible on `regs_flat` after edge N+1.
  - `wr_pending` is high from after edge N until after edge N+1, unless another request follows.
- ALIGN=2: capture at edge N+2; `wr_pending` covers both intermediate cycles.
- `wr_err` rises after the edge that samples the illegal request.
- `regs_flat` is a registered output, except the `ba_zero` gating of field 0.
- `bus_contents` is sampled only at the commit edge; its value at any other edge is irrelevant.
- Simultaneous commit of dest X and a new request for X: the commit uses the current bus value; the new request commits ALIGN edges later.

## Test plan
- Reset, then idle 5 cycles.
  - Required: all `regs_flat` fields 0, `wr_pending`=0, `wr_err`=0, `wr_count`=0.
- ALIGN=1. Request `dest_sel`=5 at edge N; bus=0x11111111 at N and 0xDEADBEEF at N+1.
  - Required: R5=0xDEADBEEF after N+1.
  - Required: `wr_count`=1, and `wr_pending` high for exactly one cycle.
- Consecutive requests to dest 16, 17, 3 with bus values 0xA, 0xB, 0xC, each aligned one edge later.
  - Required: HI=0xA, LO=0xB, R3=0xC.
  - Required: `wr_count`=3; no other field changes.
- Request `dest_sel`=20.
  - Required: `wr_err`=1 after that edge, no register changes, `wr_count` unchanged.
  - Then a legal write to R1: commits normally and `wr_err` stays 1.
- Write R0=0x1234, then drive `ba_zero`=1.
  - Required: field 0 reads 0.
  - Then `ba_zero`=0: field 0 reads 0x1234.
- ALIGN=2. Request R7, then assert `clr` asynchronously between the request and the commit edge.
  - Required: R7 stays 0, `wr_pending`=0, `wr_count`=0.
  - Then a request after `clr` deasserts: commits normally.
